vram_slot_arbiter: RTL

- Shares the single-ported VRAM read port between up to NUM_REQ video fetch engines: palette/compositor, layer 0 renderer, layer 1 renderer, and a spare slot.
- Issues at most one VRAM address per clock and runs reads fully pipelined.
- Returns data on a shared bus with a per-requester one-cycle ack.
- Requester PRIO_REQ has fixed priority because the compositor is latency-critical. All other requesters are served round-robin.

---
 rtl/vram_slot_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vram_slot_arbiter.sv
// Shares one pipelined VRAM read port between NUM_REQ fetch engines.
// PRIO_REQ always wins when eligible; the others rotate round-robin.
module vram_slot_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 1,
  parameter int PRIO_REQ     = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_strobe_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic [ADDR_W-1:0]         vram_addr_o,
  input  logic [DATA_W-1:0]         vram_data_i,
  output logic [NUM_REQ-1:0]        grant_o
);

  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = READ_LATENCY + 1;
  localparam logic [RR_W-1:0] PRIO_ID   = RR_W'(PRIO_REQ);
  localparam logic [RR_W-1:0] LAST_ID   = RR_W'(NUM_REQ - 1);
  localparam logic [RR_W:0]   NUM_REQ_W = (RR_W + 1)'(NUM_REQ);

  // Handshake: a requester raises req_strobe_i[k] with a stable address and
  // keeps both until req_ack_o[k] pulses; the ack cycle carries req_data_o.
  // At most one access per requester is in flight (r_outstanding).

  logic [NUM_REQ-1:0]           r_outstanding;
  logic [NUM_REQ-1:0]           r_grant;
  logic [NUM_REQ-1:0]           r_ack;
  logic [RR_W-1:0]              r_rr_last;
  logic [ADDR_W-1:0]            r_vram_addr;
  logic [DATA_W-1:0]            r_data;
  logic [DEPTH-1:0]             r_pipe_vld;
  logic [DEPTH-1:0][RR_W-1:0]   r_pipe_id;

  logic [NUM_REQ-1:0]           w_eligible;
  logic [NUM_REQ-1:0]           w_grant_oh;
  logic [NUM_REQ-1:0]           w_ack_oh;
  logic                         w_grant_vld;
  logic                         w_rr_grant;
  logic [RR_W-1:0]              w_grant_id;
  logic [RR_W-1:0]              w_cand;
  logic [RR_W:0]                w_sum;
  logic [ADDR_W-1:0]            w_grant_addr;

  assign w_eligible = req_strobe_i & ~r_outstanding;

  // Round-robin search starts just after the last round-robin winner and
  // wraps explicitly so non-power-of-two NUM_REQ never yields a bad index.
  always_comb begin
    w_grant_vld = 1'b0;
    w_rr_grant  = 1'b0;
    w_grant_id  = PRIO_ID;
    w_sum       = '0;
    w_cand      = '0;
    if (w_eligible[PRIO_ID]) begin
      w_grant_vld = 1'b1;
    end else begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        w_sum = {1'b0, r_rr_last} + (RR_W + 1)'(off);
        if (w_sum >= NUM_REQ_W) begin
          w_sum = w_sum - NUM_REQ_W;
        end
        w_cand = w_sum[RR_W-1:0];
        if (!w_grant_vld && (w_cand != PRIO_ID) && w_eligible[w_cand]) begin
          w_grant_vld = 1'b1;
          w_rr_grant  = 1'b1;
          w_grant_id  = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_grant_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_id == RR_W'(k)) begin
        w_grant_addr = req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_ack_oh   = r_pipe_vld[DEPTH-1] ? (NUM_REQ'(1) << r_pipe_id[DEPTH-1]) : '0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_outstanding <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_rr_last     <= LAST_ID;
      r_vram_addr   <= '0;
      r_data        <= '0;
      r_pipe_vld    <= '0;
      r_pipe_id     <= '0;
    end else begin
      r_grant <= w_grant_oh;
      if (w_grant_vld) begin
        r_vram_addr <= w_grant_addr;
      end
      if (w_rr_grant) begin
        r_rr_last <= w_grant_id;
      end
      // A requester acked this cycle becomes eligible again next cycle.
      r_outstanding <= (r_outstanding & ~r_ack) | w_grant_oh;

      // Stage j holds the access whose address was on the bus j cycles ago;
      // the last stage lines up with vram_data_i.
      r_pipe_vld[0] <= w_grant_vld;
      r_pipe_id[0]  <= w_grant_id;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end

      r_ack <= w_ack_oh;
      if (r_pipe_vld[DEPTH-1]) begin
        r_data <= vram_data_i;
      end
    end
  end

  assign grant_o     = r_grant;
  assign vram_addr_o = r_vram_addr;
  assign req_ack_o   = r_ack;
  assign req_data_o  = r_data;

endmodule
